game_frame_tx: RTL and testbench

GAME_FRAME_TX -- requirements
Module: game_frame_tx

---
 rtl/game_frame_tx.sv | 149 ++++++++++++++
 tb/tb_game_frame_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_frame_tx.sv
// game_frame_tx: serialises a snapshot of game-state fields into a byte frame
// for a UART transmitter over a valid/ready byte handshake.
//
// Frame: SYNC_BYTE, seq, field bytes (field 0 first, MSB byte first when a
// field needs two bytes), checksum = 8-bit sum of seq and all field bytes.
//
// Ports:
//   clk65MHz   - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   send       - single-cycle frame request (captures fields when idle)
//   fields     - packed fields, field i = fields[i*FIELD_W +: FIELD_W]
//   byte_data  - byte offered to the UART
//   byte_valid - byte_data valid
//   byte_ready - UART accepts byte (transfer = valid && ready at clock edge)
//   busy       - frame in progress
//   frame_done - one-cycle pulse after the checksum transfer
//   overrun    - one-cycle pulse after a send dropped while busy
//   seq        - sequence number of the next frame
module game_frame_tx #(
    parameter int unsigned NUM_FIELDS = 8,
    parameter int unsigned FIELD_W    = 12,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                          clk65MHz,
    input  logic                          rst,
    input  logic                          send,
    input  logic [NUM_FIELDS*FIELD_W-1:0] fields,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          overrun,
    output logic [7:0]                    seq
);

    localparam int unsigned BPF    = (FIELD_W <= 8) ? 1 : 2;
    localparam int unsigned NBYTES = NUM_FIELDS * BPF;
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);
    localparam int unsigned TBL    = 1 << IDX_W;
    localparam int unsigned SNAP_W = NUM_FIELDS * FIELD_W;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        CSUM
    } state_t;

    state_t            state;
    logic [SNAP_W-1:0] snap;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        csum;
    logic [7:0]        data_bytes [TBL];
    logic [IDX_W-1:0]  idx_next;
    logic [7:0]        csum_next;
    logic              xfer;

    assign xfer      = byte_valid & byte_ready;
    assign idx_next  = idx + IDX_W'(1);
    assign csum_next = csum + byte_data;

    // Flatten the snapshot into the data-byte order of the frame; the table
    // is padded to a power of two so any idx value indexes it safely.
    for (genvar k = 0; k < TBL; k++) begin : g_bytes
        if (k >= NBYTES) begin : g_pad
            assign data_bytes[k] = 8'h00;
        end else if (BPF == 1) begin : g_one
            assign data_bytes[k] = 8'(snap[k*FIELD_W +: FIELD_W]);
        end else if ((k % 2) == 0) begin : g_msb
            assign data_bytes[k] = 8'(snap[(k/2)*FIELD_W +: FIELD_W] >> 8);
        end else begin : g_lsb
            assign data_bytes[k] = 8'(snap[(k/2)*FIELD_W +: FIELD_W]);
        end
    end

    // Frame sequencer; every output is registered and only advances on a transfer.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            idx        <= '0;
            csum       <= 8'h00;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            seq        <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            overrun    <= busy & send;
            case (state)
                IDLE: begin
                    if (send) begin
                        snap       <= fields;
                        byte_data  <= SYNC_BYTE;
                        byte_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SYNC;
                    end
                end
                SYNC: begin
                    if (xfer) begin
                        byte_data <= seq;
                        csum      <= seq;
                        state     <= SEQ;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        byte_data <= data_bytes[0];
                        idx       <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if (idx == IDX_W'(NBYTES - 1)) begin
                            // running sum already includes this last byte
                            byte_data <= csum_next;
                            state     <= CSUM;
                        end else begin
                            byte_data <= data_bytes[idx_next];
                            idx       <= idx_next;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        byte_valid <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        seq        <= seq + 8'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    byte_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_frame_tx.sv
// Directed bench for game_frame_tx: a 2x12-bit instance for framing,
// backpressure, overrun/snapshot and mid-frame reset, and a 1x8-bit instance
// for sequence wrap-around with back-to-back frames.
module tb_game_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: NUM_FIELDS=2, FIELD_W=12
    logic        a_rst = 1'b1, a_send = 1'b0, a_ready = 1'b1;
    logic [23:0] a_fields = 24'h0;
    logic [7:0]  a_byte_data, a_seq;
    logic        a_byte_valid, a_busy, a_frame_done, a_overrun;

    // instance B: NUM_FIELDS=1, FIELD_W=8
    logic        b_rst = 1'b1, b_send = 1'b0, b_ready = 1'b1;
    logic [7:0]  b_fields = 8'h0;
    logic [7:0]  b_byte_data, b_seq;
    logic        b_byte_valid, b_busy, b_frame_done, b_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] EXP_A [7] = '{8'hA5, 8'h00, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'hEA};

    game_frame_tx #(.NUM_FIELDS(2), .FIELD_W(12), .SYNC_BYTE(8'hA5)) dut_a (
        .clk65MHz(clk), .rst(a_rst), .send(a_send), .fields(a_fields),
        .byte_data(a_byte_data), .byte_valid(a_byte_valid), .byte_ready(a_ready),
        .busy(a_busy), .frame_done(a_frame_done), .overrun(a_overrun), .seq(a_seq)
    );

    game_frame_tx #(.NUM_FIELDS(1), .FIELD_W(8), .SYNC_BYTE(8'hA5)) dut_b (
        .clk65MHz(clk), .rst(b_rst), .send(b_send), .fields(b_fields),
        .byte_data(b_byte_data), .byte_valid(b_byte_valid), .byte_ready(b_ready),
        .busy(b_busy), .frame_done(b_frame_done), .overrun(b_overrun), .seq(b_seq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_rst = 1'b1; a_send = 1'b0; a_ready = 1'b1;
        step();
        a_rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        step();
        step();
        n_cmp++;
        if ({a_byte_valid, a_busy, a_frame_done, a_overrun, a_byte_data, a_seq} !== {4'b0000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_a: got v%b b%b d%b o%b data %h seq %h, want all zero",
                     a_byte_valid, a_busy, a_frame_done, a_overrun, a_byte_data, a_seq);
        end
        n_cmp++;
        if ({b_byte_valid, b_busy, b_frame_done, b_overrun, b_byte_data, b_seq} !== {4'b0000, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_b: got v%b b%b d%b o%b data %h seq %h, want all zero",
                     b_byte_valid, b_busy, b_frame_done, b_overrun, b_byte_data, b_seq);
        end
        a_rst = 1'b0; b_rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        reset_a();
        a_fields = 24'h123ABC;
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            n_cmp++;
            if (c <= 7) begin
                if ({a_byte_valid, a_busy, a_frame_done, a_byte_data} !== {3'b110, EXP_A[c-1]}) begin
                    n_bad++;
                    $display("FAIL basic_byte c%0d: got v%b b%b d%b %h, want v1 b1 d0 %h",
                             c, a_byte_valid, a_busy, a_frame_done, a_byte_data, EXP_A[c-1]);
                end
            end else if (c == 8) begin
                if ({a_byte_valid, a_busy, a_frame_done, a_seq} !== {3'b001, 8'h01}) begin
                    n_bad++;
                    $display("FAIL basic_done: got v%b b%b d%b seq %h, want v0 b0 d1 seq 01",
                             a_byte_valid, a_busy, a_frame_done, a_seq);
                end
            end else begin
                if (a_frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL basic_done_pulse: got %b, want 0", a_frame_done);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int e;
        reset_a();
        a_fields = 24'h123ABC;
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            a_ready = !(c >= 3 && c <= 5);
            e = (c <= 3) ? c - 1 : (c <= 6) ? 2 : c - 4;
            n_cmp++;
            if (c <= 10) begin
                if ({a_byte_valid, a_busy, a_frame_done, a_byte_data} !== {3'b110, EXP_A[e]}) begin
                    n_bad++;
                    $display("FAIL bp_byte c%0d: got v%b b%b d%b %h, want v1 b1 d0 %h",
                             c, a_byte_valid, a_busy, a_frame_done, a_byte_data, EXP_A[e]);
                end
            end else if (c == 11) begin
                if ({a_byte_valid, a_busy, a_frame_done, a_seq} !== {3'b001, 8'h01}) begin
                    n_bad++;
                    $display("FAIL bp_done: got v%b b%b d%b seq %h, want v0 b0 d1 seq 01",
                             a_byte_valid, a_busy, a_frame_done, a_seq);
                end
            end else begin
                if (a_frame_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_done_pulse: got %b, want 0", a_frame_done);
                end
            end
            step();
        end
        a_ready = 1'b1;
    endtask

    task automatic test_overrun_snapshot();
        reset_a();
        a_fields = 24'h123ABC;
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) a_fields = 24'hFFFFFF;
            a_send = (c == 3);
            n_cmp++;
            if (a_overrun !== (c == 4)) begin
                n_bad++;
                $display("FAIL ovr_pulse c%0d: got %b, want %b", c, a_overrun, (c == 4));
            end
            n_cmp++;
            if (c <= 7) begin
                if ({a_byte_valid, a_frame_done, a_byte_data} !== {2'b10, EXP_A[c-1]}) begin
                    n_bad++;
                    $display("FAIL ovr_byte c%0d: got v%b d%b %h, want v1 d0 %h",
                             c, a_byte_valid, a_frame_done, a_byte_data, EXP_A[c-1]);
                end
            end else begin
                if ({a_frame_done, a_busy, a_seq} !== {(c == 8), 1'b0, 8'h01}) begin
                    n_bad++;
                    $display("FAIL ovr_done c%0d: got d%b b%b seq %h, want d%b b0 seq 01",
                             c, a_frame_done, a_busy, a_seq, (c == 8));
                end
            end
            step();
        end
        a_send = 1'b0;
        a_fields = 24'h123ABC;
    endtask

    task automatic test_reset_midframe();
        reset_a();
        a_fields = 24'h123ABC;
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        for (int c = 1; c <= 8; c++) step();
        n_cmp++;
        if (a_seq !== 8'h01) begin
            n_bad++;
            $display("FAIL mid_pre_seq: got %h, want 01", a_seq);
        end
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        step();
        step();
        n_cmp++;
        if ({a_byte_valid, a_byte_data} !== {1'b1, 8'h0A}) begin
            n_bad++;
            $display("FAIL mid_in_data: got v%b %h, want v1 0A", a_byte_valid, a_byte_data);
        end
        a_rst = 1'b1;
        #1;
        n_cmp++;
        if ({a_byte_valid, a_busy, a_seq, a_byte_data} !== {2'b00, 8'h00, 8'h00}) begin
            n_bad++;
            $display("FAIL mid_async: got v%b b%b seq %h data %h, want v0 b0 seq 00 data 00",
                     a_byte_valid, a_busy, a_seq, a_byte_data);
        end
        step();
        a_rst = 1'b0;
        a_send = 1'b1;
        step();
        a_send = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_cmp++;
            if (c <= 7) begin
                if ({a_byte_valid, a_byte_data} !== {1'b1, EXP_A[c-1]}) begin
                    n_bad++;
                    $display("FAIL mid_after c%0d: got v%b %h, want v1 %h",
                             c, a_byte_valid, a_byte_data, EXP_A[c-1]);
                end
            end else begin
                if ({a_frame_done, a_seq} !== {1'b1, 8'h01}) begin
                    n_bad++;
                    $display("FAIL mid_after_done: got d%b seq %h, want d1 seq 01", a_frame_done, a_seq);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back_wrap();
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
        b_fields = 8'hFF;
        b_ready = 1'b1;
        step();
        b_send = 1'b1;
        step();
        b_send = 1'b0;
        for (int f = 0; f <= 256; f++) begin
            n_cmp++;
            if ({b_byte_valid, b_byte_data} !== {1'b1, 8'hA5}) begin
                n_bad++;
                $display("FAIL wrap_sync f%0d: got v%b %h, want v1 A5", f, b_byte_valid, b_byte_data);
            end
            step();
            n_cmp++;
            if ({b_byte_valid, b_byte_data} !== {1'b1, 8'(f)}) begin
                n_bad++;
                $display("FAIL wrap_seq f%0d: got v%b %h, want v1 %h", f, b_byte_valid, b_byte_data, 8'(f));
            end
            step();
            n_cmp++;
            if ({b_byte_valid, b_byte_data} !== {1'b1, 8'hFF}) begin
                n_bad++;
                $display("FAIL wrap_field f%0d: got v%b %h, want v1 FF", f, b_byte_valid, b_byte_data);
            end
            step();
            n_cmp++;
            if ({b_byte_valid, b_byte_data} !== {1'b1, 8'(f + 255)}) begin
                n_bad++;
                $display("FAIL wrap_csum f%0d: got v%b %h, want v1 %h", f, b_byte_valid, b_byte_data, 8'(f + 255));
            end
            step();
            n_cmp++;
            if ({b_frame_done, b_busy, b_overrun, b_seq} !== {3'b100, 8'(f + 1)}) begin
                n_bad++;
                $display("FAIL wrap_done f%0d: got d%b b%b o%b seq %h, want d1 b0 o0 seq %h",
                         f, b_frame_done, b_busy, b_overrun, b_seq, 8'(f + 1));
            end
            b_send = (f < 256);
            step();
            b_send = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun_snapshot();
        test_reset_midframe();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule
